// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I instruction fields into a 32-bit instruction word.
// Two-stage valid/ready pipeline with a handshake counter.
//
// Ports:
//   iCLK, iRST          clock (rising edge), asynchronous active-high reset
//   iValid / oReady     input handshake for the field bundle
//   iFmt                000 LOAD, 001 STORE, 010 BRANCH, 011 JAL, 100 OP-IMM,
//                       101 LUI, 110/111 illegal
//   iImm                signed byte offset (I/S/B/J) or full value (LUI)
//   iRd, iRs1, iRs2     register fields
//   iFunct3             funct3 field (LOAD/STORE/BRANCH/OP-IMM)
//   oValid / iReady     output handshake
//   oInst               encoded word (NOP_WORD when rejected)
//   oErr                encoding rejected, qualifies oInst while oValid
//   oCount              output handshake count, wraps at 2^CNT_W
//
// Build option: define INST_ENC_RANGE_CHECK_EN to reject immediates that do
// not fit their format; without it, out-of-range bits are silently dropped.

module inst_encoder #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid,
    output logic             oReady,
    input  logic [2:0]       iFmt,
    input  logic [31:0]      iImm,
    input  logic [4:0]       iRd,
    input  logic [4:0]       iRs1,
    input  logic [4:0]       iRs2,
    input  logic [2:0]       iFunct3,
    output logic             oValid,
    input  logic             iReady,
    output logic [31:0]      oInst,
    output logic             oErr,
    output logic [CNT_W-1:0] oCount
);

    localparam logic [2:0] FMT_LOAD   = 3'b000;
    localparam logic [2:0] FMT_STORE  = 3'b001;
    localparam logic [2:0] FMT_BRANCH = 3'b010;
    localparam logic [2:0] FMT_JAL    = 3'b011;
    localparam logic [2:0] FMT_OPIMM  = 3'b100;
    localparam logic [2:0] FMT_LUI    = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 field registers
    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [31:0] s1_imm;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;

    // Holds oReady low until the first edge after reset release.
    logic        rdy_en;

    logic        s1_adv;
    logic        load_s1;
    logic        out_hs;

    logic [31:0] enc_word;
    logic        enc_err;

    logic        bad_i;
    logic        bad_b;
    logic        bad_j;
    logic        bad_u;

    // S1 may move into S2 whenever S2 is empty or is draining this cycle.
    assign s1_adv  = !oValid || iReady;
    assign oReady  = rdy_en && (!s1_valid || s1_adv);
    assign load_s1 = iValid && oReady;
    assign out_hs  = oValid && iReady;

`ifdef INST_ENC_RANGE_CHECK_EN
    // A value fits N signed bits when every bit from N-1 upward agrees.
    assign bad_i = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
    assign bad_b = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
    assign bad_j = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
    assign bad_u = |s1_imm[11:0];
`else
    assign bad_i = 1'b0;
    assign bad_b = 1'b0;
    assign bad_j = 1'b0;
    assign bad_u = 1'b0;
`endif

    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
        case (s1_fmt)
            FMT_LOAD: begin
                enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, OP_LOAD};
                enc_err  = bad_i;
            end
            FMT_OPIMM: begin
                enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, OP_OPIMM};
                enc_err  = bad_i;
            end
            FMT_STORE: begin
                enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3,
                            s1_imm[4:0], OP_STORE};
                enc_err  = bad_i;
            end
            FMT_BRANCH: begin
                enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1,
                            s1_f3, s1_imm[4:1], s1_imm[11], OP_BRANCH};
                enc_err  = bad_b;
            end
            FMT_JAL: begin
                enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                            s1_imm[19:12], s1_rd, OP_JAL};
                enc_err  = bad_j;
            end
            FMT_LUI: begin
                enc_word = {s1_imm[31:12], s1_rd, OP_LUI};
                enc_err  = bad_u;
            end
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_word = NOP_WORD;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_valid <= 1'b0;
            s1_fmt   <= 3'b000;
            s1_imm   <= 32'h0;
            s1_rd    <= 5'd0;
            s1_rs1   <= 5'd0;
            s1_rs2   <= 5'd0;
            s1_f3    <= 3'b000;
        end else if (load_s1) begin
            s1_valid <= 1'b1;
            s1_fmt   <= iFmt;
            s1_imm   <= iImm;
            s1_rd    <= iRd;
            s1_rs1   <= iRs1;
            s1_rs2   <= iRs2;
            s1_f3    <= iFunct3;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output register: only updates when it is empty or being consumed,
    // so a stalled word stays stable.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid <= 1'b0;
            oInst  <= 32'h0;
            oErr   <= 1'b0;
        end else if (s1_adv) begin
            oValid <= s1_valid;
            if (s1_valid) begin
                oInst <= enc_word;
                oErr  <= enc_err;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oCount <= '0;
        end else if (out_hs) begin
            oCount <= oCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized bench for inst_encoder against
// an arithmetic reference model and an in-order scoreboard.

module tb_inst_encoder;

    localparam int CW = 2;

    logic          iCLK;
    logic          iRST;
    logic          iValid;
    logic          oReady;
    logic [2:0]    iFmt;
    logic [31:0]   iImm;
    logic [4:0]    iRd;
    logic [4:0]    iRs1;
    logic [4:0]    iRs2;
    logic [2:0]    iFunct3;
    logic          oValid;
    logic          iReady;
    logic [31:0]   oInst;
    logic          oErr;
    logic [CW-1:0] oCount;

    inst_encoder #(.CNT_W(CW), .NOP_WORD(32'h00000013)) dut (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .oReady(oReady),
        .iFmt(iFmt), .iImm(iImm), .iRd(iRd), .iRs1(iRs1), .iRs2(iRs2),
        .iFunct3(iFunct3), .oValid(oValid), .iReady(iReady),
        .oInst(oInst), .oErr(oErr), .oCount(oCount)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int          errs = 0;
    int          checks = 0;
    int unsigned cnt = 0;
    logic [32:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {err, word} built from the field placement rules.
    function automatic logic [32:0] ref_enc(int fmt, int imm, int rd,
                                            int rs1, int rs2, int f3);
        int unsigned op_tab[6] = '{32'h03, 32'h23, 32'h63, 32'h6F,
                                   32'h13, 32'h37};
        int unsigned u = imm;
        int unsigned w = 0;
        bit bad = 0;
        if (fmt > 5) return {1'b1, 32'h00000013};
        case (fmt)
            0, 4: w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12)
                      | (rd << 7);
            1: w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (f3 << 12) | ((u & 32'h1F) << 7);
            2: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25)
                   | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
            3: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                   | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                   | (rd << 7);
            default: w = (u & 32'hFFFFF000) | (rd << 7);
        endcase
        w = w | op_tab[fmt];
`ifdef INST_ENC_RANGE_CHECK_EN
        case (fmt)
            0, 1, 4: bad = (imm < -2048) || (imm > 2047);
            2: bad = (imm < -4096) || (imm > 4094) || ((u & 1) != 0);
            3: bad = (imm < -1048576) || (imm > 1048574) || ((u & 1) != 0);
            default: bad = (u & 32'hFFF) != 0;
        endcase
`endif
        if (bad) return {1'b1, 32'h00000013};
        return {1'b0, w};
    endfunction

    // One clock cycle; called at a falling edge, returns at the next one.
    task automatic step(input bit v, input logic [2:0] f,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input bit rdy,
                        input logic [32:0] exp, output bit acc);
        logic [32:0] e;
        iValid = v; iFmt = f; iImm = imm; iRd = rd; iRs1 = rs1;
        iRs2 = rs2; iFunct3 = f3; iReady = rdy;
        #1;
        acc = iValid && oReady;
        if (acc) sb.push_back(exp);
        if (oValid && iReady) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {31'b0, oValid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("inst", oInst, e[31:0]);
                chk("err", {31'b0, oErr}, {31'b0, e[32]});
            end
            cnt++;
        end
        @(posedge iCLK);
        @(negedge iCLK);
        chk("count", {{(32-CW){1'b0}}, oCount}, cnt % (1 << CW));
    endtask

    task automatic idle(input bit rdy);
        bit a;
        step(0, 3'b0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b0, rdy, 33'h0, a);
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3,
                        input bit rdy, input logic [32:0] exp);
        bit a = 0;
        for (int k = 0; k < 20 && !a; k++)
            step(1, f, imm, rd, rs1, rs2, f3, rdy, exp, a);
        if (!a) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic rsend(input logic [2:0] f, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3);
        send(f, imm, rd, rs1, rs2, f3, 1,
             ref_enc(int'(f), int'(imm), int'(rd), int'(rs1),
                     int'(rs2), int'(f3)));
    endtask

    task automatic drain;
        int k = 0;
        while ((sb.size() != 0 || oValid) && k < 50) begin
            idle(1);
            k++;
        end
        chk("drain_done", sb.size(), 32'h0);
    endtask

    task automatic do_reset;
        iRST = 1; iValid = 0; iReady = 0;
        repeat (2) @(negedge iCLK);
        iRST = 0;
        sb.delete();
        cnt = 0;
        @(posedge iCLK);
        @(negedge iCLK);
        chk("rdy_after_rst", {31'b0, oReady}, 32'h1);
    endtask

    int imm_tab[16] = '{0, 1, -1, 2047, -2048, 2048, -2049, 4094, 4095,
                        -4096, -4098, 1048574, -1048576, 1048576,
                        32'h12345000, 8};

    initial begin
        bit a;
        logic [32:0] e;
        iRST = 1; iValid = 0; iReady = 0; iFmt = 0; iImm = 0;
        iRd = 0; iRs1 = 0; iRs2 = 0; iFunct3 = 0;
        repeat (3) @(negedge iCLK);
        chk("rst_valid", {31'b0, oValid}, 32'h0);
        chk("rst_inst", oInst, 32'h0);
        chk("rst_err", {31'b0, oErr}, 32'h0);
        chk("rst_count", {{(32-CW){1'b0}}, oCount}, 32'h0);
        do_reset();

        // latency: output visible after the second edge
        step(1, 3'b000, 32'd8, 5'd5, 5'd2, 5'd0, 3'b010, 1,
             {1'b0, 32'h00812283}, a);
        chk("lat_acc", {31'b0, a}, 32'h1);
        chk("lat_edge1", {31'b0, oValid}, 32'h0);
        idle(1);
        chk("lat_edge2", {31'b0, oValid}, 32'h1);
        drain();

        // directed vectors, back to back
        send(3'b001, 32'd12, 5'd0, 5'd2, 5'd5, 3'b010, 1,
             {1'b0, 32'h00512623});
        send(3'b010, -32'sd4, 5'd0, 5'd1, 5'd2, 3'b000, 1,
             {1'b0, 32'hFE208EE3});
        send(3'b011, 32'd2048, 5'd1, 5'd0, 5'd0, 3'b000, 1,
             {1'b0, 32'h001000EF});
        send(3'b111, 32'hDEADBEEF, 5'd7, 5'd9, 5'd3, 3'b101, 1,
             {1'b1, 32'h00000013});
        send(3'b110, 32'd4, 5'd1, 5'd1, 5'd1, 3'b000, 1,
             {1'b1, 32'h00000013});
`ifdef INST_ENC_RANGE_CHECK_EN
        send(3'b000, 32'd2048, 5'd5, 5'd2, 5'd0, 3'b010, 1,
             {1'b1, 32'h00000013});
        send(3'b010, 32'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1,
             {1'b1, 32'h00000013});
`else
        send(3'b000, 32'd2048, 5'd5, 5'd2, 5'd0, 3'b010, 1,
             {1'b0, 32'h80012283});
        rsend(3'b010, 32'd3, 5'd0, 5'd1, 5'd2, 3'b000);
`endif
        rsend(3'b101, 32'h12345000, 5'd10, 5'd0, 5'd0, 3'b000);
        drain();

        // back-pressure: two buffered, third stalls, then in order
        do_reset();
        e = ref_enc(4, 1, 1, 1, 0, 0);
        step(1, 3'b100, 32'd1, 5'd1, 5'd1, 5'd0, 3'b000, 0, e, a);
        e = ref_enc(4, 2, 2, 2, 0, 0);
        step(1, 3'b100, 32'd2, 5'd2, 5'd2, 5'd0, 3'b000, 0, e, a);
        e = ref_enc(4, 3, 3, 3, 0, 0);
        step(1, 3'b100, 32'd3, 5'd3, 5'd3, 5'd0, 3'b000, 0, e, a);
        chk("bp_stall", {31'b0, a}, 32'h0);
        chk("bp_ready_low", {31'b0, oReady}, 32'h0);
        step(1, 3'b100, 32'd3, 5'd3, 5'd3, 5'd0, 3'b000, 1, e, a);
        chk("bp_resume", {31'b0, a}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            chk("bp_consecutive", {31'b0, oValid}, 32'h1);
            idle(1);
        end
        chk("bp_count", {{(32-CW){1'b0}}, oCount}, 32'd3);
        chk("bp_empty", {31'b0, oValid}, 32'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0] f = 3'($urandom_range(0, 7));
            logic [31:0] im;
            bit v = ($urandom_range(0, 9) < 7);
            bit r = ($urandom_range(0, 3) != 0);
            logic [4:0] rd = 5'($urandom);
            logic [4:0] r1 = 5'($urandom);
            logic [4:0] r2 = 5'($urandom);
            logic [2:0] f3 = 3'($urandom);
            if ($urandom_range(0, 2) == 0) im = $urandom;
            else im = imm_tab[$urandom_range(0, 15)];
            step(v, f, im, rd, r1, r2, f3, r,
                 ref_enc(int'(f), int'(im), int'(rd), int'(r1),
                         int'(r2), int'(f3)), a);
        end
        drain();

        // reset with two words in flight
        send(3'b100, 32'd5, 5'd1, 5'd1, 5'd0, 3'b000, 0, ref_enc(4,5,1,1,0,0));
        send(3'b100, 32'd6, 5'd1, 5'd1, 5'd0, 3'b000, 0, ref_enc(4,6,1,1,0,0));
        iRST = 1;
        #1;
        chk("rst_async_valid", {31'b0, oValid}, 32'h0);
        chk("rst_async_count", {{(32-CW){1'b0}}, oCount}, 32'h0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("no_stale", {31'b0, oValid}, 32'h0);
        end

        // counter wrap: five handshakes on a 2-bit counter
        for (int k = 0; k < 5; k++)
            rsend(3'b000, 32'(k), 5'd1, 5'd2, 5'd0, 3'b000);
        drain();
        chk("wrap_count", {{(32-CW){1'b0}}, oCount}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
